// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// FSM state encodings, frame-format limits and counter sizing helpers.
package serial_tx_pkg;

    // Frame sequencer states, 2-bit encoding shared with the receiver.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Frame-format limits. Legal ranges: DATA_BITS 5..8, STOP_BITS 1..2,
    // CLKS_PER_BIT 1..256.
    localparam int DATA_BITS_MAX    = 8;
    localparam int STOP_BITS_MAX    = 2;
    localparam int CLKS_PER_BIT_MAX = 256;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Data-bit index counter and stop-bit counter widths.
    localparam int BIT_CNT_W  = $clog2(DATA_BITS_MAX);
    localparam int STOP_CNT_W = cnt_width(STOP_BITS_MAX);
    localparam int TICK_CNT_W_MAX = cnt_width(CLKS_PER_BIT_MAX);

endpackage

// File: rtl/serial_tx_serclk_tick.sv
// serclk sampler and rising-edge detector. serclk is a divided clock that is
// only ever sampled in the clk domain; each rising edge becomes a one-cycle
// tick. The delayed copy resets high so a serclk that is already high when
// reset is released does not produce a spurious tick.
module serclk_tick (
    input  logic clk,
    input  logic reset_n,
    input  logic serclk,
    output logic tick
);

    logic serclk_q;

    // Keep last cycle's serclk level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            serclk_q <= 1'b1;
        end else begin
            serclk_q <= serclk;
        end
    end

    assign tick = serclk & ~serclk_q;

endmodule

// File: rtl/serial_tx.sv
// Byte-wide serial transmitter: start bit, DATA_BITS data bits LSB first,
// STOP_BITS stop bits. Bit timing comes from ticks derived from serclk, each
// bit lasting exactly CLKS_PER_BIT ticks. A one-deep holding register lets the
// CPU queue the next byte while the current one is shifting, which gives
// back-to-back frames with no idle gap.
//
// Handshake: a byte is accepted on a clk edge where tx_valid and tx_ready are
// both high; tx_data is captured into the holding register on that edge.
// tx_ready is registered and is simply "holding register empty", so it drops
// the cycle after an accept and rises the cycle after the byte is moved into
// the shifter. tx_valid may stay high across handshakes; each accept takes
// exactly one byte. tx_valid may not be withdrawn by the DUT's choice: it is
// the producer's to drive, and nothing is accepted while tx_ready is low.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serclk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int TW = cnt_width(CLKS_PER_BIT);
    localparam logic [TW-1:0]         TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [STOP_CNT_W-1:0] STOP_LAST = STOP_CNT_W'(STOP_BITS - 1);

    logic tick;

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]   shifter_q, shifter_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [STOP_CNT_W-1:0]  stop_cnt_q, stop_cnt_d;
    logic                   txd_q, txd_d;
    logic                   tx_ready_q;
    logic                   busy_q;
    logic                   accept;
    logic                   bit_end;
    logic                   load_frame;

    serclk_tick u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .serclk  (serclk),
        .tick    (tick)
    );

    assign accept  = tx_valid & tx_ready_q;
    assign bit_end = (tick_cnt_q == TICK_LAST);

    // Next-state logic: handshake capture, frame sequencing on ticks, and the
    // reload of the holding byte into the shifter at a frame boundary.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shifter_d   = shifter_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        txd_d       = txd_q;
        load_frame  = 1'b0;

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (tick) begin
            if (state_q == ST_IDLE) begin
                // A tick with nothing queued is simply ignored.
                load_frame = hold_full_q;
            end else if (!bit_end) begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end else begin
                tick_cnt_d = '0;
                case (state_q)
                    ST_START: begin
                        state_d   = ST_DATA;
                        txd_d     = shifter_q[0];
                        bit_cnt_d = '0;
                    end
                    ST_DATA: begin
                        shifter_d = shifter_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d    = ST_STOP;
                            txd_d      = 1'b1;
                            stop_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            txd_d     = shifter_q[1];
                        end
                    end
                    ST_STOP: begin
                        if (stop_cnt_q == STOP_LAST) begin
                            // Queued byte goes out straight after the last stop bit.
                            load_frame = hold_full_q;
                            if (!hold_full_q) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            stop_cnt_d = stop_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Accept and reload never coincide: accept needs the holder empty,
        // reload needs it full.
        if (load_frame) begin
            shifter_d   = hold_q;
            hold_full_d = 1'b0;
            state_d     = ST_START;
            txd_d       = 1'b0;
            tick_cnt_d  = '0;
        end
    end

    // State and datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shifter_q   <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= '0;
            txd_q       <= 1'b1;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shifter_q   <= shifter_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            txd_q       <= txd_d;
            tx_ready_q  <= ~hold_full_d;
            busy_q      <= (state_d != ST_IDLE) | hold_full_d;
        end
    end

    assign txd       = txd_q;
    assign tx_ready  = tx_ready_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
